instr_fetch_unit: RTL and testbench

//  Fetch/sequencing stage directly upstream of the per-opcode execute FSMs.

---
 rtl/instr_fetch_unit_if.sv | 24 ++
 rtl/instr_fetch_unit.sv | 153 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read channel and instruction-register bus between the
// fetch unit (master) and its memory / execute FSM neighbours (slave).
interface instr_fetch_unit_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              imem_rd;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [15:0]       imem_data;
   logic [15:0]       ir;
   logic              ir_valid;
   logic              PC_inc;
   logic              done;

   modport master (
      output imem_rd, imem_addr, ir, ir_valid,
      input  imem_ack, imem_data, PC_inc, done
   );

   modport slave (
      input  imem_rd, imem_addr, ir, ir_valid,
      output imem_ack, imem_data, PC_inc, done
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch/sequencing stage: owns the PC, fetches 16-bit instructions, issues them on
// the IR bus, inserts a bubble after each done, decodes HALT and watches for hangs.
module instr_fetch_unit #(
   parameter int unsigned      ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [15:0]      BUBBLE   = 16'h0000,
   parameter logic [3:0]       HALT_OP  = 4'b1111,
   parameter int unsigned      TIMEOUT  = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   instr_fetch_unit_if.master bus,
   output logic [ADDR_W-1:0] pc,
   output logic              halted,
   output logic              fault
);

   localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_EXEC  = 3'd2,
      S_GAP   = 3'd3,
      S_HALT  = 3'd4,
      S_FAULT = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [15:0]       ir_q, ir_d;
   logic              ir_valid_q, ir_valid_d;
   logic              imem_rd_q, imem_rd_d;
   logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
   logic              halted_q, halted_d;
   logic              fault_q, fault_d;
   logic              inc_seen_q, inc_seen_d;
   logic [WDOG_W-1:0] wdog_q, wdog_d;

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         ir_q        <= BUBBLE;
         ir_valid_q  <= 1'b0;
         imem_rd_q   <= 1'b0;
         imem_addr_q <= '0;
         halted_q    <= 1'b0;
         fault_q     <= 1'b0;
         inc_seen_q  <= 1'b0;
         wdog_q      <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         ir_valid_q  <= ir_valid_d;
         imem_rd_q   <= imem_rd_d;
         imem_addr_q <= imem_addr_d;
         halted_q    <= halted_d;
         fault_q     <= fault_d;
         inc_seen_q  <= inc_seen_d;
         wdog_q      <= wdog_d;
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      ir_valid_d  = ir_valid_q;
      imem_rd_d   = imem_rd_q;
      imem_addr_d = imem_addr_q;
      halted_d    = halted_q;
      fault_d     = fault_q;
      inc_seen_d  = inc_seen_q;
      wdog_d      = wdog_q;

      case (state_q)
         S_IDLE: begin
            if (run) begin
               state_d     = S_REQ;
               imem_rd_d   = 1'b1;
               imem_addr_d = pc_q;
            end
         end

         S_REQ: begin
            if (bus.imem_ack) begin
               imem_rd_d = 1'b0;
               if (bus.imem_data[15:12] == HALT_OP) begin
                  state_d  = S_HALT;
                  halted_d = 1'b1;
               end else begin
                  state_d    = S_EXEC;
                  ir_d       = bus.imem_data;
                  ir_valid_d = 1'b1;
                  wdog_d     = '0;
                  inc_seen_d = 1'b0;
               end
            end
         end

         S_EXEC: begin
            // A done without any earlier PC_inc still advances the PC exactly once.
            if (!inc_seen_q && (bus.PC_inc || bus.done)) begin
               pc_d       = pc_q + ADDR_W'(1);
               inc_seen_d = 1'b1;
            end
            if (bus.done) begin
               state_d    = S_GAP;
               ir_d       = BUBBLE;
               ir_valid_d = 1'b0;
            end else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
               state_d    = S_FAULT;
               fault_d    = 1'b1;
               ir_d       = BUBBLE;
               ir_valid_d = 1'b0;
            end else begin
               wdog_d = wdog_q + WDOG_W'(1);
            end
         end

         S_GAP: begin
            if (run) begin
               state_d     = S_REQ;
               imem_rd_d   = 1'b1;
               imem_addr_d = pc_q;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_HALT, S_FAULT: begin
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.imem_rd   = imem_rd_q;
   assign bus.imem_addr = imem_addr_q;
   assign bus.ir        = ir_q;
   assign bus.ir_valid  = ir_valid_q;
   assign pc            = pc_q;
   assign halted        = halted_q;
   assign fault         = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: two instances (RESET_PC 0 and FF) driven by a memory
// responder and an execute-FSM stub, checked per instruction against a program-level model.
module tb_instr_fetch_unit;

   localparam int unsigned TIMEOUT = 15;
   localparam logic [15:0] BUBBLE  = 16'h0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        run_d   [2];
   logic        ack_d   [2];
   logic [15:0] data_d  [2];
   logic        inc_d   [2];
   logic        done_d  [2];

   logic        rd_o     [2];
   logic [7:0]  addr_o   [2];
   logic [15:0] ir_o     [2];
   logic        irv_o    [2];
   logic [7:0]  pc_o     [2];
   logic        halted_o [2];
   logic        fault_o  [2];

   instr_fetch_unit_if #(.ADDR_W(8)) bus_a ();
   instr_fetch_unit_if #(.ADDR_W(8)) bus_b ();

   assign bus_a.imem_ack  = ack_d[0];
   assign bus_a.imem_data = data_d[0];
   assign bus_a.PC_inc    = inc_d[0];
   assign bus_a.done      = done_d[0];
   assign bus_b.imem_ack  = ack_d[1];
   assign bus_b.imem_data = data_d[1];
   assign bus_b.PC_inc    = inc_d[1];
   assign bus_b.done      = done_d[1];

   assign rd_o[0]   = bus_a.imem_rd;
   assign addr_o[0] = bus_a.imem_addr;
   assign ir_o[0]   = bus_a.ir;
   assign irv_o[0]  = bus_a.ir_valid;
   assign rd_o[1]   = bus_b.imem_rd;
   assign addr_o[1] = bus_b.imem_addr;
   assign ir_o[1]   = bus_b.ir;
   assign irv_o[1]  = bus_b.ir_valid;

   instr_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) u_a (
      .clk    (clk),
      .rst    (rst),
      .run    (run_d[0]),
      .bus    (bus_a),
      .pc     (pc_o[0]),
      .halted (halted_o[0]),
      .fault  (fault_o[0])
   );

   instr_fetch_unit #(.ADDR_W(8), .RESET_PC(8'hFF)) u_b (
      .clk    (clk),
      .rst    (rst),
      .run    (run_d[1]),
      .bus    (bus_b),
      .pc     (pc_o[1]),
      .halted (halted_o[1]),
      .fault  (fault_o[1])
   );

   // Program-level reference state
   logic [15:0] mem [256];
   logic [7:0]  reset_pc [2];
   logic [7:0]  exp_pc   [2];
   logic        run_s    [2];
   logic        ack_pend [2];
   logic        ack_halt [2];
   logic        gap_pend [2];
   logic        halt_exp [2];
   logic        fault_exp[2];
   logic        noise    [2];
   int          mode     [2];
   int          lat      [2];
   int          wait_cnt [2];
   int          exec_cnt [2];
   int          done_at  [2];
   int          inc_at   [2];
   int          nissue   [2];
   int          ndone    [2];
   int          iss_cyc  [2][2];
   int          cyc;
   int          checks;
   int          failures;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_i(input int i, input string name, input logic [31:0] obs,
                        input logic [31:0] exp);
      chk($sformatf("%s_%0d", name, i), obs, exp);
   endtask

   // Per-instruction execute behaviour: cycle of done (0 = never) and of first PC_inc
   task automatic pick_exec(input int i);
      case (mode[i])
         1: begin done_at[i] = 4; inc_at[i] = (nissue[i] == 1) ? 2 : 4; end
         2: begin done_at[i] = 4; inc_at[i] = 0; end
         3: begin done_at[i] = 0; inc_at[i] = 3; end
         4: begin done_at[i] = 4; inc_at[i] = 4; end
         default: begin
            done_at[i] = int'($urandom_range(1, 8));
            inc_at[i]  = int'($urandom_range(0, 32'(done_at[i])));
         end
      endcase
   endtask

   task automatic noise_drive(input int i);
      inc_d[i]  = noise[i] ? 1'($urandom_range(0, 1)) : 1'b0;
      done_d[i] = noise[i] ? 1'($urandom_range(0, 1)) : 1'b0;
   endtask

   task automatic service(input int i);
      logic [15:0] instr;
      if (halt_exp[i] || fault_exp[i]) begin
         chk_i(i, "sticky_halted", 32'(halted_o[i]), 32'(halt_exp[i]));
         chk_i(i, "sticky_fault", 32'(fault_o[i]), 32'(fault_exp[i]));
         chk_i(i, "stop_rd", 32'(rd_o[i]), 32'd0);
         chk_i(i, "stop_irv", 32'(irv_o[i]), 32'd0);
         chk_i(i, "stop_ir", 32'(ir_o[i]), 32'(BUBBLE));
         chk_i(i, "stop_pc", 32'(pc_o[i]), 32'(exp_pc[i]));
         ack_d[i] = 1'b0;
         noise_drive(i);
         return;
      end
      if (ack_pend[i]) begin
         ack_pend[i] = 1'b0;
         if (ack_halt[i]) begin
            chk_i(i, "halt_flag", 32'(halted_o[i]), 32'd1);
            chk_i(i, "halt_ir", 32'(ir_o[i]), 32'(BUBBLE));
            chk_i(i, "halt_rd", 32'(rd_o[i]), 32'd0);
            chk_i(i, "halt_pc", 32'(pc_o[i]), 32'(exp_pc[i]));
            halt_exp[i] = 1'b1;
            ack_d[i]    = 1'b0;
            noise_drive(i);
            return;
         end
         chk_i(i, "issue_after_ack", 32'(irv_o[i]), 32'd1);
      end
      if (irv_o[i]) begin
         exec_cnt[i]++;
         if (exec_cnt[i] == 1) begin
            nissue[i]++;
            if (nissue[i] <= 2) iss_cyc[i][nissue[i]-1] = cyc;
            pick_exec(i);
            chk_i(i, "issue_pc", 32'(pc_o[i]), 32'(exp_pc[i]));
         end
         chk_i(i, "ir", 32'(ir_o[i]), 32'(mem[exp_pc[i]]));
         chk_i(i, "pc_mid", 32'(pc_o[i]),
               32'(8'(exp_pc[i] + ((inc_at[i] != 0 && exec_cnt[i] > inc_at[i]) ? 8'd1 : 8'd0))));
         done_d[i] = (done_at[i] != 0) && (exec_cnt[i] == done_at[i]);
         inc_d[i]  = (inc_at[i] != 0) && ((exec_cnt[i] == inc_at[i]) ||
                     (exec_cnt[i] > inc_at[i] && $urandom_range(0, 1) == 1));
         ack_d[i]  = 1'b0;
         return;
      end
      if (exec_cnt[i] != 0) begin
         if (done_at[i] != 0) begin
            chk_i(i, "exec_len", 32'(exec_cnt[i]), 32'(done_at[i]));
            chk_i(i, "gap_ir", 32'(ir_o[i]), 32'(BUBBLE));
            chk_i(i, "gap_rd", 32'(rd_o[i]), 32'd0);
            chk_i(i, "pc_after", 32'(pc_o[i]), 32'(8'(exp_pc[i] + 8'd1)));
            exp_pc[i]   = 8'(exp_pc[i] + 8'd1);
            ndone[i]++;
            gap_pend[i] = 1'b1;
         end else begin
            chk_i(i, "wdog_len", 32'(exec_cnt[i]), 32'(TIMEOUT));
            chk_i(i, "fault_flag", 32'(fault_o[i]), 32'd1);
            chk_i(i, "fault_ir", 32'(ir_o[i]), 32'(BUBBLE));
            if (inc_at[i] != 0 && inc_at[i] <= int'(TIMEOUT)) exp_pc[i] = 8'(exp_pc[i] + 8'd1);
            chk_i(i, "fault_pc", 32'(pc_o[i]), 32'(exp_pc[i]));
            fault_exp[i] = 1'b1;
         end
         exec_cnt[i] = 0;
      end else if (gap_pend[i]) begin
         gap_pend[i] = 1'b0;
         chk_i(i, "gap_one_cycle", 32'(rd_o[i]), 32'(run_s[i]));
      end
      // Memory responder: ack after lat wait cycles with the word at the requested address
      if (rd_o[i]) begin
         chk_i(i, "imem_addr", 32'(addr_o[i]), 32'(exp_pc[i]));
         if (wait_cnt[i] == lat[i]) begin
            instr       = mem[addr_o[i]];
            ack_d[i]    = 1'b1;
            data_d[i]   = instr;
            ack_pend[i] = 1'b1;
            ack_halt[i] = (instr[15:12] == 4'hF);
            wait_cnt[i] = 0;
            if (mode[i] == 0) lat[i] = int'($urandom_range(0, 3));
         end else begin
            ack_d[i]  = 1'b0;
            data_d[i] = 16'($urandom);
            wait_cnt[i]++;
         end
      end else begin
         ack_d[i]    = 1'b0;
         data_d[i]   = 16'($urandom);
         wait_cnt[i] = 0;
      end
      noise_drive(i);
   endtask

   task automatic cycle();
      for (int i = 0; i < 2; i++) run_s[i] = run_d[i];
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 2; i++) service(i);
   endtask

   // Asserts rst between clock edges, checks the asynchronous reset values, clears the model
   task automatic do_reset();
      rst = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk_i(i, "rst_pc", 32'(pc_o[i]), 32'(reset_pc[i]));
         chk_i(i, "rst_ir", 32'(ir_o[i]), 32'(BUBBLE));
         chk_i(i, "rst_irv", 32'(irv_o[i]), 32'd0);
         chk_i(i, "rst_rd", 32'(rd_o[i]), 32'd0);
         chk_i(i, "rst_addr", 32'(addr_o[i]), 32'd0);
         chk_i(i, "rst_halted", 32'(halted_o[i]), 32'd0);
         chk_i(i, "rst_fault", 32'(fault_o[i]), 32'd0);
         run_d[i] = 1'b0;  ack_d[i] = 1'b0;  inc_d[i] = 1'b0;  done_d[i] = 1'b0;
         data_d[i] = '0;
         exp_pc[i] = reset_pc[i];
         ack_pend[i] = 1'b0; ack_halt[i] = 1'b0; gap_pend[i] = 1'b0;
         halt_exp[i] = 1'b0; fault_exp[i] = 1'b0; noise[i] = 1'b0;
         wait_cnt[i] = 0; exec_cnt[i] = 0; nissue[i] = 0; ndone[i] = 0;
         done_at[i] = 0; inc_at[i] = 0;
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL tb_timeout observed=stuck expected=finish");
      $fatal(1, "bench time limit");
   end

   initial begin
      checks = 0; failures = 0; cyc = 0;
      reset_pc[0] = 8'h00; reset_pc[1] = 8'hFF;
      for (int k = 0; k < 256; k++) mem[k] = {4'($urandom_range(1, 14)), 12'($urandom)};
      mem[0] = 16'h6083; mem[1] = 16'h6083; mem[2] = 16'hF000; mem[8'hFF] = 16'h6083;
      rst = 1'b1;
      do_reset();

      // Two MOVs then HALT on A; one MOV at FF with 3-cycle memory on B, run pulsed once
      mode[0] = 1; lat[0] = 0; mode[1] = 2; lat[1] = 3;
      run_d[0] = 1'b1; run_d[1] = 1'b1;
      cycle();
      run_d[1] = 1'b0;
      for (int k = 0; k < 200 && !halt_exp[0]; k++) cycle();
      for (int k = 0; k < 5; k++) cycle();
      chk("halted_a", 32'(halted_o[0]), 32'd1);
      chk("pc_end_a", 32'(pc_o[0]), 32'd2);
      chk("issues_a", 32'(nissue[0]), 32'd2);
      chk("dones_a", 32'(ndone[0]), 32'd2);
      chk("issue_period_a", 32'(iss_cyc[0][1] - iss_cyc[0][0]), 32'd6);
      chk("pc_wrap_b", 32'(pc_o[1]), 32'h00);
      chk("issues_b", 32'(nissue[1]), 32'd1);
      chk("idle_rd_b", 32'(rd_o[1]), 32'd0);

      // Execute stub never finishes: watchdog must fire
      do_reset();
      mode[0] = 3; lat[0] = 0; run_d[0] = 1'b1;
      for (int k = 0; k < 100 && !fault_exp[0]; k++) cycle();
      for (int k = 0; k < 4; k++) cycle();
      chk("fault_a", 32'(fault_o[0]), 32'd1);
      chk("fault_irv_a", 32'(irv_o[0]), 32'd0);

      // run dropped mid-EXEC, PC_inc with done, then rst during EXEC
      do_reset();
      mode[0] = 4; lat[0] = 1; run_d[0] = 1'b1;
      for (int k = 0; k < 50 && exec_cnt[0] != 2; k++) cycle();
      chk("mid_exec_1", 32'(irv_o[0]), 32'd1);
      run_d[0] = 1'b0;
      for (int k = 0; k < 50 && ndone[0] != 1; k++) cycle();
      for (int k = 0; k < 4; k++) cycle();
      chk("stopped_rd", 32'(rd_o[0]), 32'd0);
      chk("stopped_pc", 32'(pc_o[0]), 32'd1);
      chk("stopped_issues", 32'(nissue[0]), 32'd1);
      run_d[0] = 1'b1;
      for (int k = 0; k < 50 && exec_cnt[0] != 2; k++) cycle();
      chk("mid_exec_2", 32'(irv_o[0]), 32'd1);
      #2;
      do_reset();

      // Random program, latencies, execute timing, run toggling and out-of-EXEC noise
      for (int k = 0; k < 256; k++) mem[k] = {4'($urandom_range(1, 14)), 12'($urandom)};
      for (int i = 0; i < 2; i++) begin
         mode[i] = 0; lat[i] = int'($urandom_range(0, 3)); noise[i] = 1'b1;
      end
      for (int k = 0; k < 500; k++) begin
         for (int i = 0; i < 2; i++) run_d[i] = ($urandom_range(0, 3) != 0);
         cycle();
      end
      chk("random_progress_a", 32'(nissue[0] > 10), 32'd1);
      chk("random_progress_b", 32'(nissue[1] > 10), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
